// File: rtl/mna_pkg.sv
// Shared definitions for the master network adapter: FSM states, header field
// positions and the header builder used by both the request and response sides.
package mna_pkg;

   localparam int FLIT_W   = 32;
   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;
   localparam int STRB_W   = 4;
   localparam int DEST_W   = 8;

   localparam int DEST_MSB = 31;
   localparam int DEST_LSB = 24;
   localparam int STRB_MSB = 23;
   localparam int STRB_LSB = 20;
   localparam int READ_BIT = 19;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_ADDR,
      ST_DATA,
      ST_WAIT_RESP
   } state_t;

   // Header carries routing id, byte strobes (zero for reads) and the read flag.
   function automatic logic [FLIT_W-1:0] make_header(input logic [DEST_W-1:0] dest,
                                                     input logic [STRB_W-1:0] strb,
                                                     input logic              is_read);
      logic [FLIT_W-1:0] hdr;
      hdr                    = '0;
      hdr[DEST_MSB:DEST_LSB] = dest;
      hdr[STRB_MSB:STRB_LSB] = strb;
      hdr[READ_BIT]          = is_read;
      return hdr;
   endfunction

endpackage

// File: rtl/mna_request_packetizer_if.sv
// Bundle of the AXI4-Lite request channels, NoC flit outputs and the
// completion pulse seen by the request packetizer.
interface mna_request_packetizer_if;
   import mna_pkg::*;

   logic [ADDR_W-1:0] awaddr;
   logic              awvalid;
   logic              awready;

   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              wvalid;
   logic              wready;

   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;

   logic              is_allocatable;
   logic              is_on_off;
   logic [FLIT_W-1:0] flit_data;
   logic              flit_valid;
   logic              flit_read;
   logic              flit_tail;

   logic              resp_done;

   modport slave (
      input  awaddr, awvalid, output awready,
      input  wdata, wstrb, wvalid, output wready,
      input  araddr, arvalid, output arready,
      input  is_allocatable, is_on_off,
      output flit_data, flit_valid, flit_read, flit_tail,
      input  resp_done
   );

   modport master (
      output awaddr, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      output araddr, arvalid, input arready,
      output is_allocatable, is_on_off,
      input  flit_data, flit_valid, flit_read, flit_tail,
      output resp_done
   );

endinterface

// File: rtl/mna_axi_slot.sv
// One-deep capture register for an AXI channel: loads on handshake, holds
// until the packet using it has sent its tail flit.
module mna_axi_slot #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             accept,
   input  logic             valid,
   input  logic             clear,
   input  logic [WIDTH-1:0] data_in,
   output logic             ready,
   output logic [WIDTH-1:0] data_q,
   output logic             full
);

   assign ready = accept & ~full;

   // Clear and load never coincide: clear happens only outside IDLE, where accept is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         full   <= 1'b0;
         data_q <= '0;
      end else begin
         if (clear) begin
            full <= 1'b0;
         end
         if (valid && ready) begin
            full   <= 1'b1;
            data_q <= data_in;
         end
      end
   end

endmodule

// File: rtl/mna_request_packetizer.sv
// Master adapter request stage: turns captured AXI4-Lite write/read requests
// into header/address/data NoC flits, one transaction in flight at a time.
module mna_request_packetizer
   import mna_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   mna_request_packetizer_if.slave   bus
);

   state_t state;
   state_t state_next;

   logic                     last_grant_read;
   logic                     cur_read;
   logic                     grant;
   logic                     grant_read;
   logic                     accept;
   logic                     tail_xfer;

   logic                     aw_ready, w_ready, ar_ready;
   logic                     aw_full, w_full, ar_full;
   logic [ADDR_W-1:0]        aw_q;
   logic [STRB_W+DATA_W-1:0] w_q;
   logic [ADDR_W-1:0]        ar_q;

   logic                     wr_elig, rd_elig;
   logic [FLIT_W-1:0]        flit_data_c;
   logic                     flit_valid_c;
   logic                     flit_tail_c;

   // Ready is held low during reset so the channels never appear open then.
   assign accept  = (state == ST_IDLE) & ~rst;
   assign wr_elig = aw_full & w_full;
   assign rd_elig = ar_full;

   mna_axi_slot #(.WIDTH(ADDR_W)) u_aw_slot (
      .clk     (clk),
      .rst     (rst),
      .accept  (accept),
      .valid   (bus.awvalid),
      .clear   (tail_xfer & ~cur_read),
      .data_in (bus.awaddr),
      .ready   (aw_ready),
      .data_q  (aw_q),
      .full    (aw_full)
   );

   mna_axi_slot #(.WIDTH(STRB_W + DATA_W)) u_w_slot (
      .clk     (clk),
      .rst     (rst),
      .accept  (accept),
      .valid   (bus.wvalid),
      .clear   (tail_xfer & ~cur_read),
      .data_in ({bus.wstrb, bus.wdata}),
      .ready   (w_ready),
      .data_q  (w_q),
      .full    (w_full)
   );

   mna_axi_slot #(.WIDTH(ADDR_W)) u_ar_slot (
      .clk     (clk),
      .rst     (rst),
      .accept  (accept),
      .valid   (bus.arvalid),
      .clear   (tail_xfer & cur_read),
      .data_in (bus.araddr),
      .ready   (ar_ready),
      .data_q  (ar_q),
      .full    (ar_full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_IDLE;
         last_grant_read <= 1'b1;
         cur_read        <= 1'b0;
      end else begin
         state <= state_next;
         if (grant) begin
            last_grant_read <= grant_read;
            cur_read        <= grant_read;
         end
      end
   end

   // Flit outputs come straight from state and frozen slot contents, so they
   // hold naturally while the downstream is off.
   always_comb begin
      state_next   = state;
      grant        = 1'b0;
      grant_read   = 1'b0;
      flit_valid_c = 1'b0;
      flit_tail_c  = 1'b0;
      flit_data_c  = '0;
      case (state)
         ST_IDLE: begin
            if (bus.is_allocatable && (wr_elig || rd_elig)) begin
               grant      = 1'b1;
               grant_read = rd_elig && (!wr_elig || !last_grant_read);
               state_next = ST_HDR;
            end
         end
         ST_HDR: begin
            flit_valid_c = 1'b1;
            flit_data_c  = cur_read ? make_header(ar_q[DEST_MSB:DEST_LSB], 4'b0000, 1'b1)
                                    : make_header(aw_q[DEST_MSB:DEST_LSB],
                                                  w_q[STRB_W+DATA_W-1:DATA_W], 1'b0);
            if (bus.is_on_off) begin
               state_next = ST_ADDR;
            end
         end
         ST_ADDR: begin
            flit_valid_c = 1'b1;
            flit_tail_c  = cur_read;
            flit_data_c  = cur_read ? ar_q : aw_q;
            if (bus.is_on_off) begin
               state_next = cur_read ? ST_WAIT_RESP : ST_DATA;
            end
         end
         ST_DATA: begin
            flit_valid_c = 1'b1;
            flit_tail_c  = 1'b1;
            flit_data_c  = w_q[DATA_W-1:0];
            if (bus.is_on_off) begin
               state_next = ST_WAIT_RESP;
            end
         end
         ST_WAIT_RESP: begin
            if (bus.resp_done) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign tail_xfer      = flit_valid_c & flit_tail_c & bus.is_on_off;

   assign bus.awready    = aw_ready;
   assign bus.wready     = w_ready;
   assign bus.arready    = ar_ready;
   assign bus.flit_data  = flit_data_c;
   assign bus.flit_valid = flit_valid_c;
   assign bus.flit_tail  = flit_tail_c;
   assign bus.flit_read  = cur_read & flit_valid_c;

endmodule

// File: tb/tb_mna_request_packetizer.sv
// Directed bench for the request packetizer: write/read packets, arbitration
// ties, flow-control stalls, allocation gating and mid-packet reset.
module tb_mna_request_packetizer;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   mna_request_packetizer_if bus ();

   mna_request_packetizer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_flit(input string tag, input logic [31:0] data,
                             input logic rd, input logic tail);
      check({tag, "_valid"}, {31'd0, bus.flit_valid}, 32'd1);
      check({tag, "_data"},  bus.flit_data, data);
      check({tag, "_read"},  {31'd0, bus.flit_read}, {31'd0, rd});
      check({tag, "_tail"},  {31'd0, bus.flit_tail}, {31'd0, tail});
   endtask

   initial begin
      checks             = 0;
      errors             = 0;
      rst                = 1'b1;
      bus.awaddr         = '0;
      bus.awvalid        = 1'b0;
      bus.wdata          = '0;
      bus.wstrb          = '0;
      bus.wvalid         = 1'b0;
      bus.araddr         = '0;
      bus.arvalid        = 1'b0;
      bus.is_allocatable = 1'b0;
      bus.is_on_off      = 1'b0;
      bus.resp_done      = 1'b0;

      tick();
      tick();
      check("rst_awready", {31'd0, bus.awready}, 32'd0);
      check("rst_wready",  {31'd0, bus.wready},  32'd0);
      check("rst_arready", {31'd0, bus.arready}, 32'd0);
      check("rst_valid",   {31'd0, bus.flit_valid}, 32'd0);
      check("rst_data",    bus.flit_data, 32'h0);
      check("rst_read",    {31'd0, bus.flit_read}, 32'd0);
      check("rst_tail",    {31'd0, bus.flit_tail}, 32'd0);
      rst = 1'b0;
      tick();
      check("idle_awready", {31'd0, bus.awready}, 32'd1);
      check("idle_arready", {31'd0, bus.arready}, 32'd1);

      // Single write
      bus.is_allocatable = 1'b1;
      bus.is_on_off      = 1'b1;
      bus.awaddr  = 32'h0A000010; bus.awvalid = 1'b1;
      bus.wdata   = 32'hDEADBEEF; bus.wstrb = 4'b1111; bus.wvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      check("wr_cap_awready", {31'd0, bus.awready}, 32'd0);
      check("wr_cap_valid",   {31'd0, bus.flit_valid}, 32'd0);
      tick();
      check_flit("wr_hdr", 32'h0AF00000, 1'b0, 1'b0);
      check("wr_hdr_arready", {31'd0, bus.arready}, 32'd0);
      tick();
      check_flit("wr_addr", 32'h0A000010, 1'b0, 1'b0);
      tick();
      check_flit("wr_data", 32'hDEADBEEF, 1'b0, 1'b1);
      tick();
      check("wr_wait_valid",   {31'd0, bus.flit_valid}, 32'd0);
      check("wr_wait_awready", {31'd0, bus.awready}, 32'd0);
      tick();
      check("wr_wait2_wready", {31'd0, bus.wready}, 32'd0);
      bus.resp_done = 1'b1;
      tick();
      bus.resp_done = 1'b0;
      check("wr_done_awready", {31'd0, bus.awready}, 32'd1);

      // Single read
      bus.araddr = 32'h05000004; bus.arvalid = 1'b1;
      tick();
      bus.arvalid = 1'b0;
      tick();
      check_flit("rd_hdr", 32'h05080000, 1'b1, 1'b0);
      tick();
      check_flit("rd_addr", 32'h05000004, 1'b1, 1'b1);
      tick();
      check("rd_wait_valid", {31'd0, bus.flit_valid}, 32'd0);
      bus.resp_done = 1'b1;
      tick();
      bus.resp_done = 1'b0;

      // AW one cycle ahead of W, AR alongside W: tie goes to write
      bus.awaddr = 32'h11000020; bus.awvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0;
      bus.wdata  = 32'h12345678; bus.wstrb = 4'b0011; bus.wvalid = 1'b1;
      bus.araddr = 32'h22000040; bus.arvalid = 1'b1;
      tick();
      bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      check("tie_cap_arready", {31'd0, bus.arready}, 32'd0);
      check("tie_cap_valid",   {31'd0, bus.flit_valid}, 32'd0);
      tick();
      check_flit("tie_wr_hdr", 32'h11300000, 1'b0, 1'b0);
      tick();
      check_flit("tie_wr_addr", 32'h11000020, 1'b0, 1'b0);
      tick();
      check_flit("tie_wr_data", 32'h12345678, 1'b0, 1'b1);
      tick();
      check("tie_wait_valid",   {31'd0, bus.flit_valid}, 32'd0);
      check("tie_wait_arready", {31'd0, bus.arready}, 32'd0);

      // Refill AW/W on return to IDLE while allocation is withheld
      bus.is_allocatable = 1'b0;
      bus.awaddr = 32'h33000030; bus.awvalid = 1'b1;
      bus.wdata  = 32'hCAFEF00D; bus.wstrb = 4'b1000; bus.wvalid = 1'b1;
      bus.resp_done = 1'b1;
      tick();
      bus.resp_done = 1'b0;
      check("ret_awready", {31'd0, bus.awready}, 32'd1);
      check("ret_arready", {31'd0, bus.arready}, 32'd0);
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      check("noalloc_valid1", {31'd0, bus.flit_valid}, 32'd0);
      check("noalloc_awready", {31'd0, bus.awready}, 32'd0);
      tick();
      check("noalloc_valid2", {31'd0, bus.flit_valid}, 32'd0);
      bus.is_allocatable = 1'b1;
      tick();
      check_flit("tie2_rd_hdr", 32'h22080000, 1'b1, 1'b0);
      bus.is_allocatable = 1'b0;
      tick();
      check_flit("tie2_rd_addr", 32'h22000040, 1'b1, 1'b1);
      tick();
      check("tie2_wait_valid", {31'd0, bus.flit_valid}, 32'd0);
      bus.is_allocatable = 1'b1;
      bus.resp_done = 1'b1;
      tick();
      bus.resp_done = 1'b0;
      tick();
      check_flit("w3_hdr", 32'h33800000, 1'b0, 1'b0);

      // Downstream off for three cycles during ADDR
      tick();
      check_flit("w3_addr", 32'h33000030, 1'b0, 1'b0);
      bus.is_on_off = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_flit("w3_stall", 32'h33000030, 1'b0, 1'b0);
      end
      bus.is_on_off = 1'b1;
      tick();
      check_flit("w3_data", 32'hCAFEF00D, 1'b0, 1'b1);

      // Reset in DATA
      rst = 1'b1;
      tick();
      check("mrst_valid",   {31'd0, bus.flit_valid}, 32'd0);
      check("mrst_data",    bus.flit_data, 32'h0);
      check("mrst_tail",    {31'd0, bus.flit_tail}, 32'd0);
      check("mrst_read",    {31'd0, bus.flit_read}, 32'd0);
      check("mrst_awready", {31'd0, bus.awready}, 32'd0);
      rst = 1'b0;
      tick();
      check("post_rst_valid",   {31'd0, bus.flit_valid}, 32'd0);
      check("post_rst_wready",  {31'd0, bus.wready}, 32'd1);
      check("post_rst_arready", {31'd0, bus.arready}, 32'd1);

      // Clean read after reset; resp_done on the tail cycle is ignored
      bus.araddr = 32'h44000008; bus.arvalid = 1'b1;
      tick();
      bus.arvalid = 1'b0;
      tick();
      check_flit("post_rd_hdr", 32'h44080000, 1'b1, 1'b0);
      tick();
      check_flit("post_rd_addr", 32'h44000008, 1'b1, 1'b1);
      bus.resp_done = 1'b1;
      tick();
      bus.resp_done = 1'b0;
      tick();
      check("early_done_arready", {31'd0, bus.arready}, 32'd0);
      check("early_done_valid",   {31'd0, bus.flit_valid}, 32'd0);
      bus.resp_done = 1'b1;
      tick();
      bus.resp_done = 1'b0;
      check("final_arready", {31'd0, bus.arready}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
